noc_ring_stop_rr: RTL and testbench

Parametrised single-clock ring NoC stop. It connects PORTS local IP ports to a unidirectional ring, ejects ring packets addressed to this stop into per-port receive FIFOs, and injects local traffic through a round-robin arbiter and a send FIFO. It replaces the fixed-priority stop: it adds valid/ready handshakes, configurable depth and widths, deflection when a port is full, and drop/deflect statistics.

---
 rtl/noc_ring_stop_rr.sv | 230 +++++++++++++++++++++++
 tb/tb_noc_ring_stop_rr.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ring_stop_rr.sv
// noc_ring_stop_rr
//
// Ring NoC stop with PORTS local IP ports on a unidirectional, single-clock
// ring. Packets on the ring that are addressed to this stop are ejected into
// per-port receive FIFOs. Packets for a full port are deflected, and packets
// for a port that does not exist are dropped. Local traffic is chosen by a
// round-robin arbiter, goes into a send FIFO, and is injected whenever the
// outgoing slot is free.
//
// Packet layout: {dst_addr[ADDR_W], dst_prt[PRT_W], payload[DATA_W]}, MSB first.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ring_in_valid/pkt incoming ring slot
//   ring_out_valid/pkt registered outgoing ring slot (pkt is 0 when idle)
//   tx_valid/pkt/ready per-port injection handshake (tx_pkt port k = [k*PKT_W +: PKT_W])
//   rx_valid/pkt/ready per-port receive FIFO head and pop
//   deflect_cnt       saturating count of deflected packets
//   drop_cnt          saturating count of dropped packets
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and the packet stable until the transfer. Ready
// never depends on ready itself. tx_ready depends on tx_valid and registered
// state only. rx_valid depends only on registered state.
module noc_ring_stop_rr #(
    parameter int PORTS  = 2,
    parameter int ADDR   = 0,
    parameter int ADDR_W = 8,
    parameter int PRT_W  = 4,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int PKT_W = ADDR_W + PRT_W + DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ring_in_valid,
    input  logic [PKT_W-1:0]       ring_in_pkt,
    output logic                   ring_out_valid,
    output logic [PKT_W-1:0]       ring_out_pkt,
    input  logic [PORTS-1:0]       tx_valid,
    input  logic [PORTS*PKT_W-1:0] tx_pkt,
    output logic [PORTS-1:0]       tx_ready,
    output logic [PORTS-1:0]       rx_valid,
    output logic [PORTS*PKT_W-1:0] rx_pkt,
    input  logic [PORTS-1:0]       rx_ready,
    output logic [15:0]            deflect_cnt,
    output logic [15:0]            drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] MY_ADDR   = ADDR_W'(ADDR);
    localparam logic [PRT_W:0]    NUM_PORTS = (PRT_W + 1)'(PORTS);

    // ------------------------------------------------------------------
    // Ring input classification
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] in_addr;
    logic [PRT_W-1:0]  in_prt;
    logic              is_local;
    logic              prt_ok;
    logic              drop;
    logic              deflect;
    logic              forward;
    logic [PORTS-1:0]  eject_vec;
    logic [PORTS-1:0]  rx_full;
    logic [PORTS-1:0]  rx_pop;

    assign in_addr  = ring_in_pkt[PKT_W-1 -: ADDR_W];
    assign in_prt   = ring_in_pkt[DATA_W +: PRT_W];
    assign is_local = ring_in_valid && (in_addr == MY_ADDR);
    assign prt_ok   = ({1'b0, in_prt} < NUM_PORTS);
    assign drop     = is_local && !prt_ok;
    // A valid local packet that no FIFO takes is sent on round the ring.
    assign deflect  = is_local && prt_ok && (eject_vec == '0);
    assign forward  = (ring_in_valid && !is_local) || deflect;

    // ------------------------------------------------------------------
    // Receive FIFOs (show-ahead circular buffers, one per port)
    // ------------------------------------------------------------------
    logic [PKT_W-1:0] rx_mem [PORTS][DEPTH];
    logic [PTR_W-1:0] rx_wr  [PORTS];
    logic [PTR_W-1:0] rx_rd  [PORTS];
    logic [CNT_W-1:0] rx_cnt [PORTS];

    for (genvar k = 0; k < PORTS; k++) begin : g_rx
        // Fullness uses the registered count, so a pop in the same cycle
        // does not make room for an ejection.
        assign rx_full[k]   = (rx_cnt[k] == FIFO_FULL);
        assign eject_vec[k] = is_local && (in_prt == PRT_W'(k)) && !rx_full[k];
        assign rx_valid[k]  = (rx_cnt[k] != '0);
        assign rx_pop[k]    = rx_valid[k] && rx_ready[k];
        assign rx_pkt[k*PKT_W +: PKT_W] = rx_mem[k][rx_rd[k]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PORTS; k++) begin
                rx_wr[k]  <= '0;
                rx_rd[k]  <= '0;
                rx_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PORTS; k++) begin
                if (eject_vec[k]) begin
                    rx_mem[k][rx_wr[k]] <= ring_in_pkt;
                    rx_wr[k]            <= rx_wr[k] + 1'b1;
                end
                if (rx_pop[k]) begin
                    rx_rd[k] <= rx_rd[k] + 1'b1;
                end
                case ({eject_vec[k], rx_pop[k]})
                    2'b10:   rx_cnt[k] <= rx_cnt[k] + 1'b1;
                    2'b01:   rx_cnt[k] <= rx_cnt[k] - 1'b1;
                    default: rx_cnt[k] <= rx_cnt[k];
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin injection arbiter
    // ------------------------------------------------------------------
    logic [RR_W-1:0]  rr_ptr;
    logic [RR_W-1:0]  grant_idx;
    logic [RR_W-1:0]  rr_next;
    logic [PORTS-1:0] grant;
    logic             grant_found;
    int               scan_idx;

    logic [PKT_W-1:0] snd_mem [DEPTH];
    logic [PTR_W-1:0] snd_wr;
    logic [PTR_W-1:0] snd_rd;
    logic [CNT_W-1:0] snd_cnt;
    logic             snd_push;
    logic             snd_pop;
    logic [PKT_W-1:0] snd_din;

    // Search upward from rr_ptr and wrap at PORTS. The first requester wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = 0;
        for (int i = 0; i < PORTS; i++) begin
            scan_idx = int'(rr_ptr) + i;
            if (scan_idx >= PORTS) begin
                scan_idx = scan_idx - PORTS;
            end
            if (!grant_found && tx_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = RR_W'(scan_idx);
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign tx_ready = grant & {PORTS{snd_cnt != FIFO_FULL}};
    assign snd_push = |(tx_valid & tx_ready);
    assign snd_din  = tx_pkt[int'(grant_idx)*PKT_W +: PKT_W];
    assign rr_next  = (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + 1'b1;

    // A slot left free because there was no input, an ejection or a drop
    // carries the send head in the same cycle.
    assign snd_pop  = !forward && (snd_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            snd_wr  <= '0;
            snd_rd  <= '0;
            snd_cnt <= '0;
        end else begin
            if (snd_push) begin
                snd_mem[snd_wr] <= snd_din;
                snd_wr          <= snd_wr + 1'b1;
                rr_ptr          <= rr_next;
            end
            if (snd_pop) begin
                snd_rd <= snd_rd + 1'b1;
            end
            case ({snd_push, snd_pop})
                2'b10:   snd_cnt <= snd_cnt + 1'b1;
                2'b01:   snd_cnt <= snd_cnt - 1'b1;
                default: snd_cnt <= snd_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ring output register: through-traffic first, then the send head
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_out_valid <= 1'b0;
            ring_out_pkt   <= '0;
        end else if (forward) begin
            ring_out_valid <= 1'b1;
            ring_out_pkt   <= ring_in_pkt;
        end else if (snd_pop) begin
            ring_out_valid <= 1'b1;
            ring_out_pkt   <= snd_mem[snd_rd];
        end else begin
            ring_out_valid <= 1'b0;
            ring_out_pkt   <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            deflect_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (deflect && (deflect_cnt != 16'hFFFF)) begin
                deflect_cnt <= deflect_cnt + 16'd1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_ring_stop_rr.sv
// Testbench for noc_ring_stop_rr (PORTS=4, ADDR=3, DEPTH=4, 16-bit payload).
// Scoreboard queues: the bench queues forwarded packets with the exact cycle
// they must appear in, and queues injected packets in acceptance order.
// Receive expectations are kept per port. Monitors sample on the falling edge.
module tb_noc_ring_stop_rr;

    localparam int T_PORTS  = 4;
    localparam int T_ADDR   = 3;
    localparam int T_ADDR_W = 8;
    localparam int T_PRT_W  = 4;
    localparam int T_DATA_W = 16;
    localparam int T_DEPTH  = 4;
    localparam int PKT_W    = T_ADDR_W + T_PRT_W + T_DATA_W;

    localparam int K_NONE = 0;
    localparam int K_FWD  = 1;
    localparam int K_EJ   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     ring_in_valid;
    logic [PKT_W-1:0]         ring_in_pkt;
    logic                     ring_out_valid;
    logic [PKT_W-1:0]         ring_out_pkt;
    logic [T_PORTS-1:0]       tx_valid;
    logic [T_PORTS*PKT_W-1:0] tx_pkt;
    logic [T_PORTS-1:0]       tx_ready;
    logic [T_PORTS-1:0]       rx_valid;
    logic [T_PORTS*PKT_W-1:0] rx_pkt;
    logic [T_PORTS-1:0]       rx_ready;
    logic [15:0]              deflect_cnt;
    logic [15:0]              drop_cnt;

    noc_ring_stop_rr #(
        .PORTS (T_PORTS),
        .ADDR  (T_ADDR),
        .ADDR_W(T_ADDR_W),
        .PRT_W (T_PRT_W),
        .DATA_W(T_DATA_W),
        .DEPTH (T_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ring_in_valid (ring_in_valid),
        .ring_in_pkt   (ring_in_pkt),
        .ring_out_valid(ring_out_valid),
        .ring_out_pkt  (ring_out_pkt),
        .tx_valid      (tx_valid),
        .tx_pkt        (tx_pkt),
        .tx_ready      (tx_ready),
        .rx_valid      (rx_valid),
        .rx_pkt        (rx_pkt),
        .rx_ready      (rx_ready),
        .deflect_cnt   (deflect_cnt),
        .drop_cnt      (drop_cnt)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_accepted = 0;
    bit timed_inj = 1'b0;

    logic [PKT_W-1:0] fwd_q[$];
    int               fwd_cyc_q[$];
    logic [PKT_W-1:0] inj_q[$];
    int               inj_cyc_q[$];
    logic [PKT_W-1:0] rx_q[T_PORTS][$];
    logic [PKT_W-1:0] tx_src_q[T_PORTS][$];
    int               grant_exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk(input int a, input int p, input int d);
        return {T_ADDR_W'(a), T_PRT_W'(p), T_DATA_W'(d)};
    endfunction

    function automatic int tx_pending();
        int s = 0;
        for (int k = 0; k < T_PORTS; k++) s += tx_src_q[k].size();
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one ring slot for one cycle and record what it should produce.
    task automatic ring_drive(input bit v, input logic [PKT_W-1:0] p, input int kind);
        ring_in_valid = v;
        ring_in_pkt   = v ? p : '0;
        if (kind == K_FWD) begin
            fwd_q.push_back(p);
            fwd_cyc_q.push_back(cyc + 1);
        end
        if (kind == K_EJ) rx_q[int'(p[T_DATA_W +: T_PRT_W])].push_back(p);
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((fwd_q.size() + inj_q.size() + tx_pending()) != 0 && t < budget) begin
            ring_drive(1'b0, '0, K_NONE);
            t++;
        end
        check("idle_timeout", 64'(t >= budget), 64'(0));
    endtask

    task automatic flush_all();
        fwd_q.delete();
        fwd_cyc_q.delete();
        inj_q.delete();
        inj_cyc_q.delete();
        grant_exp_q.delete();
        for (int k = 0; k < T_PORTS; k++) begin
            rx_q[k].delete();
            tx_src_q[k].delete();
        end
    endtask

    // Each port presents the head of its source queue and holds it until accepted.
    initial begin : tx_agent
        logic [T_PORTS-1:0] acc;
        tx_valid = '0;
        tx_pkt   = '0;
        forever begin
            @(negedge clk);
            acc = tx_valid & tx_ready;
            check("tx_ready_onehot", 64'($countones(tx_ready) > 1), 64'(0));
            if (!rst) begin
                for (int k = 0; k < T_PORTS; k++) begin
                    if (acc[k]) begin
                        if (grant_exp_q.size() > 0) check("rr_order", 64'(k), 64'(grant_exp_q.pop_front()));
                        inj_q.push_back(tx_pkt[k*PKT_W +: PKT_W]);
                        inj_cyc_q.push_back(timed_inj ? cyc + 2 : -1);
                        n_accepted++;
                    end
                end
            end
            @(posedge clk);
            #2;
            for (int k = 0; k < T_PORTS; k++) begin
                if (acc[k] && tx_src_q[k].size() > 0) void'(tx_src_q[k].pop_front());
                tx_valid[k] = (tx_src_q[k].size() > 0);
                tx_pkt[k*PKT_W +: PKT_W] = (tx_src_q[k].size() > 0) ? tx_src_q[k][0] : '0;
            end
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin : ring_mon
        int c;
        while (fwd_cyc_q.size() > 0 && fwd_cyc_q[0] < cyc) begin
            check("ring_fwd_missing", 64'(fwd_q.pop_front()), 64'(0));
            void'(fwd_cyc_q.pop_front());
        end
        if (ring_out_valid) begin
            if (fwd_cyc_q.size() > 0 && fwd_cyc_q[0] == cyc) begin
                check("ring_fwd", 64'(ring_out_pkt), 64'(fwd_q.pop_front()));
                void'(fwd_cyc_q.pop_front());
            end else if (inj_q.size() > 0) begin
                check("ring_inj", 64'(ring_out_pkt), 64'(inj_q.pop_front()));
                c = inj_cyc_q.pop_front();
                if (c >= 0) check("inj_latency", 64'(cyc), 64'(c));
            end else begin
                check("ring_spurious", 64'(ring_out_pkt), 64'(0));
            end
        end else begin
            check("ring_idle_pkt", 64'(ring_out_pkt), 64'(0));
        end
    end

    always @(negedge clk) begin : rx_mon
        for (int k = 0; k < T_PORTS; k++) begin
            if (rx_valid[k] && rx_ready[k]) begin
                if (rx_q[k].size() > 0) check("rx_pkt", 64'(rx_pkt[k*PKT_W +: PKT_W]), 64'(rx_q[k].pop_front()));
                else check("rx_spurious", 64'(rx_pkt[k*PKT_W +: PKT_W]), 64'(0));
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst           = 1'b1;
        ring_in_valid = 1'b0;
        ring_in_pkt   = '0;
        rx_ready      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ring_valid", 64'(ring_out_valid), 64'(0));
        check("rst_ring_pkt", 64'(ring_out_pkt), 64'(0));
        check("rst_rx_valid", 64'(rx_valid), 64'(0));
        check("rst_tx_ready", 64'(tx_ready), 64'(0));
        check("rst_deflect", 64'(deflect_cnt), 64'(0));
        check("rst_drop", 64'(drop_cnt), 64'(0));

        // Eject and forward
        ring_drive(1'b1, mk(T_ADDR, 1, 'hA5), K_EJ);
        check("eject_valid", 64'(rx_valid), 64'(4'b0010));
        check("eject_payload", 64'(rx_pkt[1*PKT_W +: T_DATA_W]), 64'('hA5));
        ring_drive(1'b1, mk(5, 2, 'h1234), K_FWD);
        check("fwd_valid", 64'(ring_out_valid), 64'(1));
        check("fwd_pkt", 64'(ring_out_pkt), 64'(mk(5, 2, 'h1234)));
        rx_ready = 4'b0010;
        ring_drive(1'b0, '0, K_NONE);
        rx_ready = '0;
        check("eject_popped", 64'(rx_valid), 64'(0));

        // Deflect on a full port, including a same-cycle pop
        for (int i = 0; i < T_DEPTH; i++) ring_drive(1'b1, mk(T_ADDR, 0, 'h100 + i), K_EJ);
        check("fill_valid", 64'(rx_valid), 64'(4'b0001));
        ring_drive(1'b1, mk(T_ADDR, 0, 'h1FF), K_FWD);
        check("deflect_1", 64'(deflect_cnt), 64'(1));
        rx_ready = 4'b0001;
        ring_drive(1'b1, mk(T_ADDR, 0, 'h2FF), K_FWD);
        rx_ready = '0;
        check("deflect_pop_same_cycle", 64'(deflect_cnt), 64'(2));
        ring_drive(1'b1, mk(T_ADDR, 0, 'h300), K_EJ);
        check("deflect_after_pop", 64'(deflect_cnt), 64'(2));
        rx_ready = 4'b0001;
        for (int i = 0; i < 5; i++) ring_drive(1'b0, '0, K_NONE);
        rx_ready = '0;
        check("deflect_drained", 64'(rx_valid), 64'(0));

        // Drop to nonexistent ports
        ring_drive(1'b1, mk(T_ADDR, T_PORTS, 'h44), K_NONE);
        ring_drive(1'b1, mk(T_ADDR, 15, 'h45), K_NONE);
        ring_drive(1'b0, '0, K_NONE);
        check("drop_cnt", 64'(drop_cnt), 64'(2));
        check("drop_no_rx", 64'(rx_valid), 64'(0));

        // Round-robin with every port requesting; one packet targets this stop
        timed_inj = 1'b1;
        grant_exp_q = '{0, 1, 2, 3, 0};
        tx_src_q[0].push_back(mk(7, 0, 'h500));
        tx_src_q[0].push_back(mk(7, 1, 'h504));
        tx_src_q[1].push_back(mk(T_ADDR, 2, 'h501));
        tx_src_q[2].push_back(mk(9, 0, 'h502));
        tx_src_q[3].push_back(mk(1, 3, 'h503));
        wait_idle(40);
        timed_inj = 1'b0;
        check("rr_all_granted", 64'(grant_exp_q.size()), 64'(0));
        check("no_loopback", 64'(rx_valid), 64'(0));

        // Through-stream blocks injection until the send FIFO fills
        begin
            int base;
            base = n_accepted;
            for (int i = 0; i < 8; i++) begin
                if (i == 0) for (int j = 0; j < 6; j++) tx_src_q[2].push_back(mk(8, 2, 'h700 + j));
                ring_drive(1'b1, mk(6, 0, 'h600 + i), K_FWD);
            end
            check("block_accepts", 64'(n_accepted - base), 64'(T_DEPTH));
            check("block_tx_ready", 64'(tx_ready), 64'(0));
            check("block_tx_valid", 64'(tx_valid[2]), 64'(1));
        end
        // Ejection frees the slot for the send head in the same cycle
        ring_drive(1'b1, mk(T_ADDR, 3, 'h6AA), K_EJ);
        check("reuse_valid", 64'(ring_out_valid), 64'(1));
        check("reuse_pkt", 64'(ring_out_pkt), 64'(mk(8, 2, 'h700)));
        check("reuse_eject", 64'(rx_valid), 64'(4'b1000));
        wait_idle(40);
        rx_ready = 4'b1000;
        ring_drive(1'b0, '0, K_NONE);
        rx_ready = '0;

        // Reset mid-traffic with 3 packets in the send FIFO
        ring_drive(1'b1, mk(T_ADDR, 2, 'h800), K_EJ);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) for (int j = 0; j < 3; j++) tx_src_q[1].push_back(mk(4, 1, 'h900 + j));
            ring_drive(1'b1, mk(6, 1, 'hA00 + i), K_FWD);
        end
        check("pre_rst_held", 64'(inj_q.size()), 64'(3));
        rst = 1'b1;
        ring_drive(1'b1, mk(T_ADDR, 0, 'h999), K_NONE);
        rst = 1'b0;
        ring_in_valid = 1'b0;
        ring_in_pkt   = '0;
        flush_all();
        #2;
        check("mid_rst_ring_valid", 64'(ring_out_valid), 64'(0));
        check("mid_rst_ring_pkt", 64'(ring_out_pkt), 64'(0));
        check("mid_rst_rx_valid", 64'(rx_valid), 64'(0));
        check("mid_rst_tx_ready", 64'(tx_ready), 64'(0));
        check("mid_rst_deflect", 64'(deflect_cnt), 64'(0));
        check("mid_rst_drop", 64'(drop_cnt), 64'(0));
        tick();
        for (int i = 0; i < 12; i++) ring_drive(1'b0, '0, K_NONE);

        // Deflect counter saturation
        for (int i = 0; i < T_DEPTH; i++) ring_drive(1'b1, mk(T_ADDR, 0, 'hB00 + i), K_EJ);
        for (int i = 0; i < 65534; i++) ring_drive(1'b1, mk(T_ADDR, 0, i), K_FWD);
        check("deflect_fffe", 64'(deflect_cnt), 64'(16'hFFFE));
        for (int i = 0; i < 3; i++) ring_drive(1'b1, mk(T_ADDR, 0, 'hC00 + i), K_FWD);
        check("deflect_sat", 64'(deflect_cnt), 64'(16'hFFFF));
        ring_drive(1'b0, '0, K_NONE);
        rx_ready = 4'b0001;
        for (int i = 0; i < 5; i++) ring_drive(1'b0, '0, K_NONE);
        rx_ready = '0;
        wait_idle(20);

        // Final report
        check("end_fwd_q", 64'(fwd_q.size()), 64'(0));
        check("end_inj_q", 64'(inj_q.size()), 64'(0));
        for (int k = 0; k < T_PORTS; k++) check("end_rx_q", 64'(rx_q[k].size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
